// File: rtl/uart_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cfg_pkg
//  Purpose  : Shared constants, FSM state encodings and helper functions for
//             the configurable UART core (uart_cfg_core, uart_tick16_gen).
//  Contents : PARITY_* mode constants, tx_state_t / rx_state_t encodings,
//             calc_baud_div() divisor rounding, parity_bit() generator.
//  Revision : 1.0  initial release
// ============================================================================
package uart_cfg_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Clocks per 16x tick, rounded to nearest and never below 1.
   function automatic int calc_baud_div(input int freq, input int baud);
      int div;
      div = (freq + 8 * baud) / (16 * baud);
      if (div < 1) div = 1;
      return div;
   endfunction

   // Parity bit for up to 8 data bits; narrower words are zero-extended,
   // which does not change the XOR reduction.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick16_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tick16_gen
//  Purpose  : Free-running divider that emits a one-clock tick16 pulse every
//             DIV system clocks (16 ticks per UART bit period).
//  Ports    : clock  - system clock
//             reset  - asynchronous active-high reset
//             tick16 - one-clock pulse when the counter wraps
//  Revision : 1.0  initial release
// ============================================================================
module uart_tick16_gen #(
   parameter int DIV = 1
) (
   input  logic clock,
   input  logic reset,
   output logic tick16
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // With DIV == 1 the counter sits at 0 and tick16 is permanently high.
   assign tick16 = (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (tick16) cnt <= '0;
      else             cnt <= cnt + CW'(1);
   end

endmodule
`default_nettype wire

// File: rtl/uart_cfg_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cfg_core
//  Purpose  : Configurable UART (5..8 data bits, none/even/odd parity, 1 or 2
//             stop bits) with ready/valid handshakes, 16x oversampled
//             majority-vote receiver and parity/framing/overrun reporting.
//  Ports    : clock, reset          - system clock, async active-high reset
//             tx_data/valid/ready   - transmit handshake
//             tx_ser_data_out       - serial line out (idles high)
//             rx_ser_data_in        - serial line in (asynchronous)
//             rx_data/valid/ready   - receive handshake
//             rx_parity_err         - parity mismatch for held byte
//             rx_frame_err          - stop bit sampled low for held byte
//             rx_overrun            - sticky, frame dropped while rx_valid
//  Revision : 1.0  initial release
// ============================================================================
module uart_cfg_core
   import uart_cfg_pkg::*;
#(
   parameter int SYSTM_OPERN_FREQ = 11059200,
   parameter int REQD_BAUD_RATE   = 9600,
   parameter int DATA_BITS        = 8,
   parameter int PARITY_MODE      = 0,
   parameter int STOP_BITS        = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_ser_data_out,
   input  logic                 rx_ser_data_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int         DIV       = calc_baud_div(SYSTM_OPERN_FREQ, REQD_BAUD_RATE);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam tx_state_t  TX_AFTER_DATA = (PARITY_MODE != PARITY_NONE) ? TX_PARITY : TX_STOP;
   localparam rx_state_t  RX_AFTER_DATA = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;

   logic tick16;

   uart_tick16_gen #(.DIV(DIV)) u_tick16_gen (
      .clock  (clock),
      .reset  (reset),
      .tick16 (tick16)
   );

   // ------------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------------
   tx_state_t            tx_state, tx_state_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   logic [3:0]           tx_tcnt, tx_tcnt_n;
   logic [2:0]           tx_bcnt, tx_bcnt_n;
   logic                 tx_par, tx_par_n;
   logic                 tx_pend, tx_pend_n;
   logic                 tx_line_n;
   logic                 tx_bit_end;

   // A byte accepted in IDLE waits (tx_pend) for the next tick boundary, so
   // no second byte may be taken during that short gap.
   assign tx_ready = (tx_state == TX_IDLE) && !tx_pend;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state        <= TX_IDLE;
         tx_shift        <= '0;
         tx_tcnt         <= '0;
         tx_bcnt         <= '0;
         tx_par          <= 1'b0;
         tx_pend         <= 1'b0;
         tx_ser_data_out <= 1'b1;
      end else begin
         tx_state        <= tx_state_n;
         tx_shift        <= tx_shift_n;
         tx_tcnt         <= tx_tcnt_n;
         tx_bcnt         <= tx_bcnt_n;
         tx_par          <= tx_par_n;
         tx_pend         <= tx_pend_n;
         tx_ser_data_out <= tx_line_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_shift_n = tx_shift;
      tx_tcnt_n  = tx_tcnt;
      tx_bcnt_n  = tx_bcnt;
      tx_par_n   = tx_par;
      tx_pend_n  = tx_pend;
      tx_bit_end = tick16 && (tx_tcnt == 4'd15);

      // The 4-bit tick count wraps to 0 on the 16th tick of every bit.
      if ((tx_state != TX_IDLE) && tick16) tx_tcnt_n = tx_tcnt + 4'd1;

      case (tx_state)
         TX_IDLE: begin
            if (tx_valid && tx_ready) begin
               tx_shift_n = tx_data;
               tx_par_n   = parity_bit(8'(tx_data), PARITY_MODE);
               tx_pend_n  = 1'b1;
            end else if (tx_pend && tick16) begin
               tx_state_n = TX_START;
               tx_tcnt_n  = 4'd0;
               tx_pend_n  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_n = TX_DATA;
               tx_bcnt_n  = 3'd0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_n = tx_shift >> 1;
               if (tx_bcnt == LAST_DATA) begin
                  tx_state_n = TX_AFTER_DATA;
                  tx_bcnt_n  = 3'd0;
               end else begin
                  tx_bcnt_n  = tx_bcnt + 3'd1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_n = TX_STOP;
               tx_bcnt_n  = 3'd0;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bcnt == LAST_STOP) tx_state_n = TX_IDLE;
               else                      tx_bcnt_n  = tx_bcnt + 3'd1;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase

      // Line level is registered from the next state so the pin never glitches.
      case (tx_state_n)
         TX_START:  tx_line_n = 1'b0;
         TX_DATA:   tx_line_n = tx_shift_n[0];
         TX_PARITY: tx_line_n = tx_par_n;
         default:   tx_line_n = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------------
   logic                 rx_meta, rx_sync;
   rx_state_t            rx_state, rx_state_n;
   logic [3:0]           rx_tcnt, rx_tcnt_n;
   logic [2:0]           rx_bcnt, rx_bcnt_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
   logic                 s7, s7_n, s8, s8_n;
   logic                 rx_bit, rx_bit_n;
   logic                 rx_perr, rx_perr_n;
   logic                 rx_wait_high, rx_wait_high_n;
   logic                 vote, rx_mid, rx_end;
   logic                 frame_done, frame_ferr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_tcnt      <= '0;
         rx_bcnt      <= '0;
         rx_shift     <= '0;
         s7           <= 1'b1;
         s8           <= 1'b1;
         rx_bit       <= 1'b1;
         rx_perr      <= 1'b0;
         rx_wait_high <= 1'b0;
      end else begin
         rx_meta      <= rx_ser_data_in;
         rx_sync      <= rx_meta;
         rx_state     <= rx_state_n;
         rx_tcnt      <= rx_tcnt_n;
         rx_bcnt      <= rx_bcnt_n;
         rx_shift     <= rx_shift_n;
         s7           <= s7_n;
         s8           <= s8_n;
         rx_bit       <= rx_bit_n;
         rx_perr      <= rx_perr_n;
         rx_wait_high <= rx_wait_high_n;
      end
   end

   always_comb begin
      rx_state_n     = rx_state;
      rx_tcnt_n      = rx_tcnt;
      rx_bcnt_n      = rx_bcnt;
      rx_shift_n     = rx_shift;
      s7_n           = s7;
      s8_n           = s8;
      rx_bit_n       = rx_bit;
      rx_perr_n      = rx_perr;
      rx_wait_high_n = rx_wait_high;
      frame_done     = 1'b0;
      frame_ferr     = 1'b0;

      // Majority of the tick-7 and tick-8 samples and the live tick-9 sample.
      vote   = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
      rx_mid = tick16 && (rx_tcnt == 4'd9);
      rx_end = tick16 && (rx_tcnt == 4'd15);

      if ((rx_state != RX_IDLE) && tick16) begin
         rx_tcnt_n = rx_tcnt + 4'd1;
         if (rx_tcnt == 4'd7) s7_n     = rx_sync;
         if (rx_tcnt == 4'd8) s8_n     = rx_sync;
         if (rx_tcnt == 4'd9) rx_bit_n = vote;
      end

      case (rx_state)
         RX_IDLE: begin
            // After a low stop bit (e.g. break) the line must return high
            // before another start edge is accepted.
            if (rx_wait_high) begin
               if (rx_sync) rx_wait_high_n = 1'b0;
            end else if (!rx_sync) begin
               rx_state_n = RX_START;
               rx_tcnt_n  = 4'd0;
               rx_perr_n  = 1'b0;
            end
         end
         RX_START: begin
            if (rx_mid && vote) begin
               rx_state_n = RX_IDLE;
            end else if (rx_end) begin
               rx_state_n = RX_DATA;
               rx_bcnt_n  = 3'd0;
            end
         end
         RX_DATA: begin
            if (rx_end) begin
               rx_shift_n = {rx_bit, rx_shift[DATA_BITS-1:1]};
               if (rx_bcnt == LAST_DATA) rx_state_n = RX_AFTER_DATA;
               else                      rx_bcnt_n  = rx_bcnt + 3'd1;
            end
         end
         RX_PARITY: begin
            if (rx_end) begin
               rx_perr_n  = rx_bit ^ parity_bit(8'(rx_shift), PARITY_MODE);
               rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            // Finish at mid-stop so the next start edge can be caught early.
            if (rx_mid) begin
               frame_done     = 1'b1;
               frame_ferr     = !vote;
               rx_wait_high_n = !vote;
               rx_state_n     = RX_IDLE;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // Output holding register with drop-on-full overrun behaviour.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data       <= rx_shift;
            rx_parity_err <= rx_perr;
            rx_frame_err  <= frame_ferr;
            rx_valid      <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid      <= 1'b0;
         end

         if (frame_done && rx_valid && !rx_ready) rx_overrun <= 1'b1;
         else if (rx_valid && rx_ready)           rx_overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire
